// File: rtl/cache_pkg.sv
// Shared definitions for the cache line fill controller.
//   fill_state_e : controller state encoding (IDLE, ARB, EVICT, FILL)
//   calc_off_w   : byte-offset width of a line, log2(words * bytes per word)
//   calc_wcnt_w  : word counter width, log2(words) plus one bit so that a
//                  count of exactly WORDS_PER_LINE can be represented
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    EVICT = 2'd2,
    FILL  = 2'd3
  } fill_state_e;

  function automatic int calc_off_w(input int words, input int word_bytes);
    return $clog2(words * word_bytes);
  endfunction

  function automatic int calc_wcnt_w(input int words);
    return $clog2(words) + 1;
  endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Up-counter with synchronous clear, count enable and terminal-count flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return to zero (has priority over en)
//   en         : increment by one
//   cnt        : current count
//   done       : cnt equals TERMINAL
module fill_word_counter #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/cache_line_fill_ctrl.sv
// Cache miss controller: optional write-back of a dirty victim line, then a
// word-by-word line fill from main memory, with a response timeout.
//   clk, rst_n        : clock, asynchronous active-low reset
//   miss_detected     : miss strobe from tag match (used in IDLE only)
//   miss_address      : missing byte address
//   victim_dirty      : victim needs write-back (sampled with the miss)
//   victim_tag        : tag of the victim line (sampled with the miss)
//   proceed           : arbiter grant (used in ARB only)
//   mem_data_valid    : memory read response, in request order
//   fsm_busy          : pipeline stall
//   mem_en / mem_we   : memory request strobe / write (evict) qualifier
//   mem_address       : memory request address
//   cache_address     : data-array address (read in EVICT, write in FILL)
//   write_data_array  : data-array write enable
//   write_tag_array   : tag-array write enable, pulses with the last word
//   tag_out           : {miss tag, valid}
//   err               : sticky response-timeout flag, cleared by next miss
module cache_line_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int WORDS_PER_LINE = 8,
  parameter int WORD_BYTES     = 2,
  parameter int TAG_W          = 6,
  parameter int TIMEOUT        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              victim_dirty,
  input  logic [TAG_W-1:0]  victim_tag,
  input  logic              proceed,
  input  logic              mem_data_valid,
  output logic              fsm_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [ADDR_W-1:0] cache_address,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [TAG_W:0]    tag_out,
  output logic              err
);

  localparam int OFF_W  = calc_off_w(WORDS_PER_LINE, WORD_BYTES);
  localparam int WCNT_W = calc_wcnt_w(WORDS_PER_LINE);
  localparam int HI_W   = ADDR_W - OFF_W;
  localparam int IDLE_W = $clog2(TIMEOUT);

  fill_state_e       state_q, state_d;
  // Only the line-aligned upper bits are stored; offsets are concatenated
  // in, so address arithmetic can never carry into index or tag bits.
  logic [HI_W-1:0]   line_hi_q, line_hi_d;
  logic [HI_W-1:0]   victim_hi_q, victim_hi_d;
  logic              dirty_q, dirty_d;
  logic [TAG_W:0]    tag_out_q, tag_out_d;
  logic              err_q, err_d;

  logic [WCNT_W-1:0] req_cnt, rsp_cnt, evict_cnt;
  logic              req_done, rsp_done, evict_last;
  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_last;

  logic in_fill, rsp_valid, rsp_last, timeout_hit, start_ctrs, enter_fill;
  logic unused_sigs;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [HI_W-1:0]   hi,
                                                  input logic [WCNT_W-1:0] idx);
    logic [OFF_W-1:0] off;
    off = OFF_W'(32'(idx) * WORD_BYTES);
    return {hi, off};
  endfunction

  assign in_fill     = (state_q == FILL);
  assign rsp_valid   = in_fill && mem_data_valid && !rsp_done;
  assign rsp_last    = rsp_valid && (rsp_cnt == WCNT_W'(WORDS_PER_LINE - 1));
  // Idle count TIMEOUT-1 plus another silent cycle means TIMEOUT is reached.
  assign timeout_hit = in_fill && !mem_data_valid && idle_last;
  assign start_ctrs  = ((state_q == ARB) && proceed) || ((state_q == EVICT) && evict_last);
  assign enter_fill  = (state_d == FILL) && (state_q != FILL);
  assign unused_sigs = ^{miss_address[OFF_W-1:0], idle_cnt};

  fill_word_counter #(.WIDTH(WCNT_W), .TERMINAL(WORDS_PER_LINE)) u_req_cnt (
    .clk(clk), .rst_n(rst_n), .clr(start_ctrs), .en(in_fill && !req_done),
    .cnt(req_cnt), .done(req_done)
  );

  fill_word_counter #(.WIDTH(WCNT_W), .TERMINAL(WORDS_PER_LINE)) u_rsp_cnt (
    .clk(clk), .rst_n(rst_n), .clr(start_ctrs), .en(rsp_valid),
    .cnt(rsp_cnt), .done(rsp_done)
  );

  fill_word_counter #(.WIDTH(WCNT_W), .TERMINAL(WORDS_PER_LINE - 1)) u_evict_cnt (
    .clk(clk), .rst_n(rst_n), .clr(start_ctrs), .en(state_q == EVICT),
    .cnt(evict_cnt), .done(evict_last)
  );

  fill_word_counter #(.WIDTH(IDLE_W), .TERMINAL(TIMEOUT - 1)) u_idle_cnt (
    .clk(clk), .rst_n(rst_n), .clr(enter_fill || (in_fill && mem_data_valid)),
    .en(in_fill), .cnt(idle_cnt), .done(idle_last)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      line_hi_q   <= '0;
      victim_hi_q <= '0;
      dirty_q     <= 1'b0;
      tag_out_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_hi_q   <= line_hi_d;
      victim_hi_q <= victim_hi_d;
      dirty_q     <= dirty_d;
      tag_out_q   <= tag_out_d;
      err_q       <= err_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_detected) state_d = ARB;
      ARB:     if (proceed) state_d = dirty_q ? EVICT : FILL;
      EVICT:   if (evict_last) state_d = FILL;
      FILL:    if (rsp_last || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Miss capture and error flag
  always_comb begin
    line_hi_d   = line_hi_q;
    victim_hi_d = victim_hi_q;
    dirty_d     = dirty_q;
    tag_out_d   = tag_out_q;
    err_d       = err_q;
    if ((state_q == IDLE) && miss_detected) begin
      line_hi_d   = miss_address[ADDR_W-1:OFF_W];
      // Victim shares the miss index; only its tag field differs.
      victim_hi_d = miss_address[ADDR_W-1:OFF_W];
      victim_hi_d[HI_W-1 -: TAG_W] = victim_tag;
      dirty_d     = victim_dirty;
      tag_out_d   = {miss_address[ADDR_W-1 -: TAG_W], 1'b1};
      err_d       = 1'b0;
    end
    if (timeout_hit) begin
      err_d = 1'b1;
    end
  end

  // Outputs
  always_comb begin
    fsm_busy         = (state_q != IDLE);
    mem_en           = 1'b0;
    mem_we           = 1'b0;
    mem_address      = '0;
    cache_address    = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    tag_out          = tag_out_q;
    err              = err_q;
    case (state_q)
      EVICT: begin
        mem_en        = 1'b1;
        mem_we        = 1'b1;
        mem_address   = word_addr(victim_hi_q, evict_cnt);
        cache_address = word_addr(line_hi_q, evict_cnt);
      end
      FILL: begin
        mem_en           = !req_done;
        mem_address      = req_done ? '0 : word_addr(line_hi_q, req_cnt);
        cache_address    = word_addr(line_hi_q, rsp_cnt);
        write_data_array = rsp_valid;
        write_tag_array  = rsp_last;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
module tb_cache_line_fill_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        victim_dirty = 1'b0;
  logic [5:0]  victim_tag = '0;
  logic        proceed = 1'b0;
  logic        mem_data_valid = 1'b0;
  logic        fsm_busy, mem_en, mem_we, write_data_array, write_tag_array, err;
  logic [15:0] mem_address, cache_address;
  logic [6:0]  tag_out;

  always #5 clk = ~clk;

  cache_line_fill_ctrl #(
    .ADDR_W(16), .WORDS_PER_LINE(8), .WORD_BYTES(2), .TAG_W(6), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected), .miss_address(miss_address),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag), .proceed(proceed),
    .mem_data_valid(mem_data_valid), .fsm_busy(fsm_busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_address(mem_address), .cache_address(cache_address),
    .write_data_array(write_data_array), .write_tag_array(write_tag_array),
    .tag_out(tag_out), .err(err)
  );

  typedef struct {logic we; logic [15:0] maddr; logic [15:0] caddr; logic chk_c;} req_t;
  typedef struct {logic [15:0] caddr; logic last;} wr_t;

  req_t req_q[$];
  wr_t  wr_q[$];
  int   pend_q[$];
  int   total = 0, bad = 0;
  int   cyc = 0, budget = 1000, stray_cnt = 0, n_wr = 0;
  int   last_rsp_cyc = 0, tag_cyc = 0;
  logic valid_next = 1'b0;
  logic [6:0] exp_tag = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responses change just after the clock edge so each one spans a full cycle.
  always @(posedge clk) begin
    cyc++;
    #1 mem_data_valid = valid_next;
  end

  // Scoreboard pops plus memory model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_q.size() == 0) begin
        check("unexp_req", {31'b0, mem_en}, 0);
      end else if (mem_en) begin
        req_t r;
        r = req_q.pop_front();
        check("req_we", {31'b0, mem_we}, {31'b0, r.we});
        check("req_addr", {16'b0, mem_address}, {16'b0, r.maddr});
        if (r.chk_c) check("evict_caddr", {16'b0, cache_address}, {16'b0, r.caddr});
        $display("req  t=%0d we=%0d addr=%h", cyc, mem_we, mem_address);
      end
      if (wr_q.size() == 0) begin
        check("stray_write", {31'b0, write_data_array}, 0);
        check("stray_tag", {31'b0, write_tag_array}, 0);
      end else if (write_data_array) begin
        wr_t w;
        w = wr_q.pop_front();
        check("wr_caddr", {16'b0, cache_address}, {16'b0, w.caddr});
        check("tag_we", {31'b0, write_tag_array}, {31'b0, w.last});
        if (w.last) begin
          check("tag_out", {25'b0, tag_out}, {25'b0, exp_tag});
          tag_cyc = cyc;
        end
        n_wr++;
        last_rsp_cyc = cyc;
        $display("wr   t=%0d caddr=%h tag_we=%0d", cyc, cache_address, write_tag_array);
      end else begin
        check("tag_no_data", {31'b0, write_tag_array}, 0);
      end
      if (mem_en && !mem_we) pend_q.push_back(cyc + LAT);
    end
    valid_next = 1'b0;
    if (stray_cnt > 0) begin
      valid_next = 1'b1;
      stray_cnt--;
    end else if (pend_q.size() > 0 && pend_q[0] == cyc + 1) begin
      void'(pend_q.pop_front());
      if (budget > 0) begin
        valid_next = 1'b1;
        budget--;
      end
    end
  end

  task automatic do_miss(input logic [15:0] a, input logic d, input logic [5:0] vt, input int nwr);
    logic [15:0] lb, vb;
    lb = a & 16'hFFF0;
    vb = {vt, 10'b0} | (a & 16'h03F0);
    exp_tag = {a[15:10], 1'b1};
    if (d) for (int i = 0; i < 8; i++) req_q.push_back('{1'b1, 16'(vb + 2*i), 16'(lb + 2*i), 1'b1});
    for (int i = 0; i < 8; i++) req_q.push_back('{1'b0, 16'(lb + 2*i), 16'h0, 1'b0});
    for (int i = 0; i < nwr; i++) wr_q.push_back('{16'(lb + 2*i), (i == 7)});
    n_wr = 0;
    @(negedge clk);
    miss_address = a; victim_dirty = d; victim_tag = vt; miss_detected = 1'b1;
    @(negedge clk);
    miss_detected = 1'b0;
    check("busy_arb", {31'b0, fsm_busy}, 1);
    check("err_cleared", {31'b0, err}, 0);
    $display("miss t=%0d addr=%h dirty=%0d vtag=%h", cyc, a, d, vt);
  endtask

  task automatic do_proceed(input int hold);
    for (int i = 0; i < hold; i++) begin
      check("arb_no_mem", {31'b0, mem_en}, 0);
      check("arb_busy", {31'b0, fsm_busy}, 1);
      @(negedge clk);
    end
    proceed = 1'b1;
    @(negedge clk);
    proceed = 1'b0;
    check("start_mem_en", {31'b0, mem_en}, 1);
  endtask

  // mode 0: normal completion, mode 1: timeout abort
  task automatic wait_idle(input int mode);
    int n;
    n = 0;
    while (fsm_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {31'b0, fsm_busy}, 0);
    check("err", {31'b0, err}, (mode == 1) ? 1 : 0);
    if (mode == 0) check("busy_fall_delay", 32'(cyc - tag_cyc), 1);
    else           check("timeout_delay", 32'(cyc - last_rsp_cyc), 17);
    check("req_q_empty", 32'(req_q.size()), 0);
    check("wr_q_empty", 32'(wr_q.size()), 0);
    $display("idle t=%0d err=%0d", cyc, err);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, fsm_busy}, 0);
    check("rst_mem_en", {31'b0, mem_en}, 0);
    check("rst_tag_out", {25'b0, tag_out}, 0);
    check("rst_err", {31'b0, err}, 0);
    rst_n = 1'b1;

    // 1: clean miss
    do_miss(16'h1234, 1'b0, 6'h00, 8);
    do_proceed(0);
    wait_idle(0);

    // 2: dirty miss
    do_miss(16'h1234, 1'b1, 6'h3F, 8);
    do_proceed(0);
    wait_idle(0);

    // 3: grant delayed 5 cycles
    do_miss(16'h1234, 1'b0, 6'h00, 8);
    do_proceed(5);
    wait_idle(0);

    // 4: only three responses, then timeout
    budget = 3;
    do_miss(16'h0A50, 1'b0, 6'h00, 3);
    do_proceed(0);
    wait_idle(1);
    budget = 1000;

    // 5: reset after fifth response; miss also clears err
    do_miss(16'h1234, 1'b0, 6'h00, 8);
    do_proceed(0);
    n = 0;
    while (n_wr < 5 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    check("rsp_before_reset", 32'(n_wr), 5);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, fsm_busy}, 0);
    check("arst_mem_en", {31'b0, mem_en}, 0);
    check("arst_mem_we", {31'b0, mem_we}, 0);
    check("arst_maddr", {16'b0, mem_address}, 0);
    check("arst_caddr", {16'b0, cache_address}, 0);
    check("arst_wda", {31'b0, write_data_array}, 0);
    check("arst_wta", {31'b0, write_tag_array}, 0);
    check("arst_tag_out", {25'b0, tag_out}, 0);
    check("arst_err", {31'b0, err}, 0);
    req_q.delete(); wr_q.delete(); pend_q.delete();
    valid_next = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    do_miss(16'h2468, 1'b1, 6'h15, 8);
    do_proceed(0);
    wait_idle(0);

    // 6: stray valids in IDLE, ARB and after the last word
    stray_cnt = 2;
    repeat (4) @(negedge clk);
    do_miss(16'hC0DE, 1'b0, 6'h00, 8);
    stray_cnt = 3;
    do_proceed(5);
    wait_idle(0);
    stray_cnt = 2;
    repeat (4) @(negedge clk);
    check("stray_no_busy", {31'b0, fsm_busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_line_fill_ctrl.md
Name: cache_line_fill_ctrl

Overview:
Parametrised cache miss controller, successor to the fixed 8-word, 16-bit fill FSM. It handles one miss at a time. If the victim line is dirty, it first writes the line back to main memory, then fills the line word by word. Cache write addresses are tracked by counting memory responses, so memory latency is arbitrary. A response timeout raises a sticky error. It sits between the cache tag-match logic, the memory arbiter and the single-port main memory.

Parameters:
ADDR_W, 16, byte address width
WORDS_PER_LINE, 8, words per cache line; power of two, ≥2
WORD_BYTES, 2, bytes per word; power of two
TAG_W, 6, tag width; tag = addr[ADDR_W-1 -: TAG_W]
TIMEOUT, 16, max cycles in FILL with no mem_data_valid before abort; ≥2
Derived: OFF_W = log2(WORDS_PER_LINE*WORD_BYTES). Constraint: TAG_W+OFF_W ≤ ADDR_W.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
miss_detected  in  1  tag-match reports a miss (sampled in IDLE only)
miss_address  in  ADDR_W  missing byte address
victim_dirty  in  1  chosen victim line is dirty (sampled with miss_detected)
victim_tag  in  TAG_W  tag of victim line (sampled with miss_detected)
proceed  in  1  arbiter grant; sampled only in ARB
mem_data_valid  in  1  memory read response valid, in request order
fsm_busy  out  1  stall to pipeline
mem_en  out  1  memory request strobe
mem_we  out  1  request is write (evict)
mem_address  out  ADDR_W  memory request address
cache_address  out  ADDR_W  data-array address (read in EVICT, write in FILL)
write_data_array  out  1  data-array write enable
write_tag_array  out  1  tag-array write enable
tag_out  out  TAG_W+1  {miss tag, valid=1}
err  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. Reset clears every register and returns the state to IDLE.
- Reset values: all outputs 0, including err. tag_out resets to 0.
- Registered state is one of IDLE, ARB, EVICT, FILL. All outputs are decoded from registered state and counters; there is no combinational path from an input to an output except:
  - write_data_array, which depends on mem_data_valid;
  - write_tag_array, which depends on mem_data_valid.
- Capture: in IDLE with miss_detected=1, the block latches:
  - line_base = {miss_address[ADDR_W-1:OFF_W], 0}
  - victim_base = {victim_tag, miss_address[ADDR_W-TAG_W-1:OFF_W], 0}
  - the dirty bit
  - tag_out = {miss tag, 1}
  It also clears err, sets fsm_busy (visible next cycle) and goes to ARB.
- miss_detected outside IDLE is ignored.
- ARB: no memory activity. proceed=1 clears the word counters and moves to EVICT if the latched dirty bit is set, otherwise to FILL. While proceed=0 the block stays in ARB.
- EVICT: one write per cycle, for i = 0..WORDS_PER_LINE-1.
  - mem_en=1, mem_we=1.
  - mem_address = victim_base + i*WORD_BYTES; cache_address = line_base + i*WORD_BYTES (data-array read).
  - After i = WORDS_PER_LINE-1, clear counters and go to FILL.
- FILL, request side: while req_cnt < WORDS_PER_LINE, drive mem_en=1, mem_we=0, mem_address = line_base + req_cnt*WORD_BYTES, and increment req_cnt each cycle. When requests are exhausted, mem_en=0.
- FILL, response side:
  - cache_address = line_base + rsp_cnt*WORD_BYTES.
  - write_data_array = mem_data_valid.
  - rsp_cnt increments on each valid.
  - mem_data_valid may arrive no earlier than the cycle after its request.
- Last response (rsp_cnt = WORDS_PER_LINE-1 and mem_data_valid=1): write_data_array=1 and write_tag_array=1 in the same cycle. The next state is IDLE and fsm_busy=0 from the next cycle.
- Timeout:
  - The idle counter resets on entering FILL and on each valid, and increments otherwise.
  - When it reaches TIMEOUT: go to IDLE, set err=1 and clear fsm_busy. No tag write occurs; written words are left stale.
- mem_data_valid in IDLE, ARB or EVICT, or beyond the last word, is ignored: no writes and no count.
- Address arithmetic is offset-only. Counters span log2(WORDS_PER_LINE) bits plus terminal detect. There is never a carry into the index or tag bits.
- Async reset mid-operation aborts immediately. No tag write occurs; mem_en drops asynchronously.

Decomposition:
- Shared package cache_pkg:
  - state enum fill_state_e {IDLE, ARB, EVICT, FILL};
  - OFF_W and WCNT_W as localparam functions using clog2.
- One sub-module: fill_word_counter. It is a parametrised up-counter with clear, enable and a terminal-count flag, instanced for req_cnt, rsp_cnt and the evict count.

Test Plan:
All scenarios use default parameters.
1. Clean miss on 0x1234, proceed 1 cycle after busy, memory latency 4:
   - mem_address runs 0x1230..0x123E over 8 cycles with mem_we=0;
   - write_data_array runs 4 cycles later at cache_address 0x1230..0x123E;
   - write_tag_array coincides with the 8th write; tag_out=0x09;
   - fsm_busy falls the next cycle.
2. Dirty miss on 0x1234 with victim_tag=0x3F:
   - 8 cycles with mem_we=1 and mem_address 0xFE30..0xFE3E, cache_address 0x1230..0x123E;
   - then fill identical to scenario 1.
3. proceed held low for 5 cycles: mem_en=0 and fsm_busy=1 throughout ARB; the fill starts on the cycle after proceed rises.
4. Only 3 responses returned: after 16 silent cycles, err=1, state is IDLE, fsm_busy=0, write_tag_array never pulses; the next miss clears err.
5. rst_n pulsed low after the 5th response: all outputs 0 immediately; a subsequent miss completes normally.
6. Stray mem_data_valid in IDLE and ARB, and 2 extra pulses after the last word: no write_data_array or write_tag_array.
